fifo_uart_tx: RTL and testbench

Consumer-side drain for the synchronous FIFO: whenever the FIFO is non-empty, pops one byte and serialises it as an 8N1 UART frame on a single output pin. It sits between the FIFO's read port and the board's serial pin, replacing manual `rd_btn` reads so stored `sw_data` bytes can be observed on a host terminal. It guarantees exactly one FIFO read per transmitted frame, with byte order preserved.

---
 rtl/fifo_uart_tx_pkg.sv | 15 +
 rtl/fifo_uart_tx_if.sv | 24 ++
 rtl/fifo_uart_tx_baud_gen.sv | 34 +++
 rtl/fifo_uart_tx.sv | 99 +++++++++
 tb/tb_fifo_uart_tx.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-to-UART drain: FSM encoding and frame constants.
package fifo_uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_START = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int FRAME_BITS           = 10;
    localparam int DATA_BITS            = FRAME_BITS - 2;
endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial line; master is the drain, slave is the FIFO/board side.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic       uart_tx;
    logic       tx_busy;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output uart_tx,
        output tx_busy
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  uart_tx,
        input  tx_busy
    );
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses bit_done_o on the last count.
module uart_baud_gen
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic bit_done_o
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        if (clr_i || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done_o = (cnt_q == CNT_LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO one byte at a time and sends each byte as an 8N1 UART frame.
//
// state | meaning
// IDLE  | line high, waiting for a non-empty FIFO
// POP   | one-cycle read strobe to the FIFO
// WAIT  | FIFO data becomes valid, captured on exit
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (line high), then pop again or go idle
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic           clk_50mhz,
    input  logic           rst_btn,
    fifo_uart_tx_if.master bus
);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       bit_done;
    logic       baud_clr;
    logic       tx;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_i      (clk_50mhz),
        .rst_i      (rst_btn),
        .clr_i      (baud_clr),
        .bit_done_o (bit_done)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.fifo_empty) state_d = ST_POP;
            end
            ST_POP: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d = ST_START;
                shift_d = bus.fifo_dout;
            end
            ST_START: begin
                if (bit_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // fifo_empty is only looked at here and in IDLE
                if (bit_done) state_d = bus.fifo_empty ? ST_IDLE : ST_POP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Restart the bit period on every state entry.
    assign baud_clr = (state_d != state_q);

    always_ff @(posedge clk_50mhz or posedge rst_btn) begin
        if (rst_btn) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = shift_q[0];
            default:  tx = 1'b1;
        endcase
    end

    assign bus.uart_tx    = tx;
    assign bus.fifo_rd_en = (state_q == ST_POP);
    assign bus.tx_busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and CLKS_PER_BIT=4.
module tb_fifo_uart_tx;
    localparam int CPB       = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic clk_50mhz = 1'b0;
    logic rst_btn   = 1'b1;

    fifo_uart_tx_if bus ();

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .rst_btn   (rst_btn),
        .bus       (bus)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    logic [7:0] mem [16];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       empty_force_lo = 1'b0;
    int         rd_pulses = 0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr) && !empty_force_lo;

    always @(posedge clk_50mhz) begin
        cyc <= cyc + 1;
        if (bus.fifo_rd_en) begin
            bus.fifo_dout <= mem[rd_ptr[3:0]];
            rd_ptr        <= rd_ptr + 1;
            rd_pulses     <= rd_pulses + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[3:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [FRAME_CYC-1:0] frame_of(input logic [7:0] b);
        logic [FRAME_CYC-1:0] f;
        for (int i = 0; i < FRAME_CYC; i++) begin
            int idx;
            idx = i / CPB;
            if (idx == 0)      f[i] = 1'b0;
            else if (idx == 9) f[i] = 1'b1;
            else               f[i] = b[idx-1];
        end
        return f;
    endfunction

    task automatic test_reset;
        rst_btn = 1'b1;
        repeat (3) @(negedge clk_50mhz);
        total++;
        if (bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got tx=%b busy=%b rd=%b, want 1 0 0",
                     bus.uart_tx, bus.tx_busy, bus.fifo_rd_en);
        end
        rst_btn = 1'b0;
        repeat (3) @(negedge clk_50mhz);
        total++;
        if (bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0 || rd_pulses !== 0) begin
            bad++;
            $display("FAIL reset_release_idle: got tx=%b busy=%b pops=%0d, want 1 0 0",
                     bus.uart_tx, bus.tx_busy, rd_pulses);
        end
    endtask

    task automatic test_empty;
        int p0;
        p0 = rd_pulses;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_50mhz);
            total++;
            if (bus.fifo_rd_en !== 1'b0 || bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
                bad++;
                $display("FAIL empty_idle cycle %0d: got rd=%b tx=%b busy=%b, want 0 1 0",
                         i, bus.fifo_rd_en, bus.uart_tx, bus.tx_busy);
            end
        end
        total++;
        if (rd_pulses - p0 !== 0) begin
            bad++;
            $display("FAIL empty_pops: got %0d, want 0", rd_pulses - p0);
        end
    endtask

    task automatic test_single;
        logic [FRAME_CYC-1:0] got;
        int p0;
        int extra_rd;
        p0 = rd_pulses;
        extra_rd = 0;
        push(8'hAA);
        @(negedge clk_50mhz);
        total++;
        if (bus.fifo_rd_en !== 1'b1 || bus.tx_busy !== 1'b1 || bus.uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL single_pop: got rd=%b busy=%b tx=%b, want 1 1 1",
                     bus.fifo_rd_en, bus.tx_busy, bus.uart_tx);
        end
        @(negedge clk_50mhz);
        total++;
        if (bus.fifo_rd_en !== 1'b0 || bus.tx_busy !== 1'b1 || bus.uart_tx !== 1'b1) begin
            bad++;
            $display("FAIL single_wait: got rd=%b busy=%b tx=%b, want 0 1 1",
                     bus.fifo_rd_en, bus.tx_busy, bus.uart_tx);
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge clk_50mhz);
            got[i] = bus.uart_tx;
            if (bus.fifo_rd_en === 1'b1) extra_rd++;
        end
        total++;
        if (got !== frame_of(8'hAA)) begin
            bad++;
            $display("FAIL single_frame: got %h, want %h", got, frame_of(8'hAA));
        end
        @(negedge clk_50mhz);
        total++;
        if (bus.tx_busy !== 1'b0 || bus.uart_tx !== 1'b1 || extra_rd !== 0) begin
            bad++;
            $display("FAIL single_end_idle: got busy=%b tx=%b rd_in_frame=%0d, want 0 1 0",
                     bus.tx_busy, bus.uart_tx, extra_rd);
        end
        total++;
        if (rd_pulses - p0 !== 1) begin
            bad++;
            $display("FAIL single_pops: got %0d, want 1", rd_pulses - p0);
        end
    endtask

    task automatic test_three;
        logic [7:0]           bytes [3];
        logic [FRAME_CYC-1:0] got;
        logic [7:0]           dec;
        int p0, n, pop_cyc, prev_pop;
        bytes[0] = 8'hAA;
        bytes[1] = 8'hBB;
        bytes[2] = 8'hCC;
        p0 = rd_pulses;
        pop_cyc = 0;
        prev_pop = 0;
        push(bytes[0]);
        push(bytes[1]);
        push(bytes[2]);
        for (int f = 0; f < 3; f++) begin
            n = 0;
            do begin
                @(negedge clk_50mhz);
                n++;
                if (bus.fifo_rd_en === 1'b1) pop_cyc = cyc;
            end while (bus.uart_tx === 1'b1 && n < 50);
            total++;
            if (f == 0 && n !== 3) begin
                bad++;
                $display("FAIL three_latency: got %0d cycles to start bit, want 3", n);
            end else if (f > 0 && (CPB + n - 1) !== CPB + 2) begin
                bad++;
                $display("FAIL three_gap frame %0d: got %0d high cycles, want %0d",
                         f, CPB + n - 1, CPB + 2);
            end
            if (f > 0) begin
                total++;
                if (pop_cyc - prev_pop !== FRAME_CYC + 2) begin
                    bad++;
                    $display("FAIL three_pop_spacing frame %0d: got %0d, want %0d",
                             f, pop_cyc - prev_pop, FRAME_CYC + 2);
                end
            end
            prev_pop = pop_cyc;
            got[0] = bus.uart_tx;
            for (int i = 1; i < FRAME_CYC; i++) begin
                @(negedge clk_50mhz);
                got[i] = bus.uart_tx;
            end
            for (int k = 0; k < 8; k++) dec[k] = got[CPB * (k + 1) + CPB / 2];
            total++;
            if (got !== frame_of(bytes[f]) || dec !== bytes[f]) begin
                bad++;
                $display("FAIL three_frame %0d: got byte %h line %h, want byte %h",
                         f, dec, got, bytes[f]);
            end
        end
        @(negedge clk_50mhz);
        total++;
        if (bus.tx_busy !== 1'b0 || rd_pulses - p0 !== 3) begin
            bad++;
            $display("FAIL three_end: got busy=%b pops=%0d, want 0 3",
                     bus.tx_busy, rd_pulses - p0);
        end
    endtask

    task automatic test_empty_during;
        logic [FRAME_CYC-1:0] got;
        int p0;
        p0 = rd_pulses;
        empty_force_lo = 1'b1;
        push(8'h3C);
        repeat (3) @(negedge clk_50mhz);
        got[0] = bus.uart_tx;
        for (int i = 1; i < FRAME_CYC; i++) begin
            @(negedge clk_50mhz);
            got[i] = bus.uart_tx;
            if (i == 20) empty_force_lo = 1'b0;
        end
        total++;
        if (got !== frame_of(8'h3C)) begin
            bad++;
            $display("FAIL empty_during_frame: got %h, want %h", got, frame_of(8'h3C));
        end
        repeat (20) @(negedge clk_50mhz);
        total++;
        if (bus.tx_busy !== 1'b0 || bus.uart_tx !== 1'b1 || rd_pulses - p0 !== 1) begin
            bad++;
            $display("FAIL empty_during_end: got busy=%b tx=%b pops=%0d, want 0 1 1",
                     bus.tx_busy, bus.uart_tx, rd_pulses - p0);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        int viol;
        p0 = rd_pulses;
        viol = 0;
        push(8'h55);
        repeat (3) @(negedge clk_50mhz);
        repeat (CPB * 4 + 1) @(negedge clk_50mhz);
        total++;
        if (bus.uart_tx !== 1'b0 || bus.tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_bit3: got tx=%b busy=%b, want 0 1", bus.uart_tx, bus.tx_busy);
        end
        #2;
        rst_btn = 1'b1;
        #1;
        total++;
        if (bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_async: got tx=%b busy=%b rd=%b, want 1 0 0",
                     bus.uart_tx, bus.tx_busy, bus.fifo_rd_en);
        end
        repeat (3) @(negedge clk_50mhz);
        rst_btn = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_50mhz);
            if (bus.uart_tx !== 1'b1 || bus.tx_busy !== 1'b0 || bus.fifo_rd_en !== 1'b0) viol++;
        end
        total++;
        if (viol !== 0 || rd_pulses - p0 !== 1) begin
            bad++;
            $display("FAIL reset_mid_after: got bad_cycles=%0d pops=%0d, want 0 1",
                     viol, rd_pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_three();
        test_empty_during();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
